// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the decode-to-execute stage register.
// Contents:
//   - default XLEN / ADDR_W widths
//   - occupancy encoding (EMPTY/ONE/FULL) and the matching state enum
//   - standard decode-to-execute payload field widths and offsets, so
//     producers and consumers pack/unpack the opaque payload identically
//   - occ_encode(): maps the two entry valid bits onto the occupancy code
package pipe_stage_skid_reg_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 5;

    // Payload layout, LSB first: rs1 | rs2 | imm | alu | load | wb | misc
    localparam int RS1_W       = 32;
    localparam int RS2_W       = 32;
    localparam int IMM_W       = 32;
    localparam int ALU_CTRL_W  = 4;
    localparam int LD_CTRL_W   = 3;
    localparam int WB_CTRL_W   = 3;
    localparam int MISC_CTRL_W = 6;

    localparam int RS1_OFF       = 0;
    localparam int RS2_OFF       = RS1_OFF + RS1_W;
    localparam int IMM_OFF       = RS2_OFF + RS2_W;
    localparam int ALU_CTRL_OFF  = IMM_OFF + IMM_W;
    localparam int LD_CTRL_OFF   = ALU_CTRL_OFF + ALU_CTRL_W;
    localparam int WB_CTRL_OFF   = LD_CTRL_OFF + LD_CTRL_W;
    localparam int MISC_CTRL_OFF = WB_CTRL_OFF + WB_CTRL_W;
    localparam int DEC_EX_DATA_W = MISC_CTRL_OFF + MISC_CTRL_W;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } occ_state_e;

    // The skid entry is only ever filled while the main entry is valid,
    // so a valid skid entry alone means FULL.
    function automatic logic [1:0] occ_encode(input logic main_v, input logic skid_v);
        logic [1:0] occ;
        if (skid_v) begin
            occ = OCC_FULL;
        end else if (main_v) begin
            occ = OCC_ONE;
        end else begin
            occ = OCC_EMPTY;
        end
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake and data bundle of the decode-to-execute stage register.
// Signal names follow the stage ports (_in = into the stage, _out = out of it).
//   master : the environment (decode upstream, execute downstream, flush agent)
//   slave  : the stage register itself
interface pipe_stage_skid_reg_if
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DEC_EX_DATA_W
);
    logic              flush_in;
    logic              up_valid_in;
    logic              up_ready_out;
    logic [DATA_W-1:0] payload_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic              rf_wr_en_in;
    logic [XLEN-1:0]   iadder_in;
    logic              branch_taken_in;
    logic              down_valid_out;
    logic              down_ready_in;
    logic [DATA_W-1:0] payload_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic              rf_wr_en_out;
    logic [XLEN-1:0]   iadder_out;
    logic [1:0]        occupancy_out;

    modport master (
        output flush_in, up_valid_in, payload_in, rd_addr_in, rf_wr_en_in,
               iadder_in, branch_taken_in, down_ready_in,
        input  up_ready_out, down_valid_out, payload_out, rd_addr_out,
               rf_wr_en_out, iadder_out, occupancy_out
    );

    modport slave (
        input  flush_in, up_valid_in, payload_in, rd_addr_in, rf_wr_en_in,
               iadder_in, branch_taken_in, down_ready_in,
        output up_ready_out, down_valid_out, payload_out, rd_addr_out,
               rf_wr_en_out, iadder_out, occupancy_out
    );
endinterface

// File: rtl/pipe_stage_skid_reg_stage_entry_reg.sv
// One stage entry: a valid bit plus {payload, rd_addr, rf_wr_en, iadder}.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              drop the entry (fields keep their last value)
//   load_i               capture the *_i fields and mark the entry valid
//   branch_taken_i       when set (and ALIGN_TARGET) bit 0 of iadder is cleared on load
//   valid_o, *_o         stored entry
// clear_i wins over load_i.
module stage_entry_reg #(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 112,
    parameter int ALIGN_TARGET = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] payload_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rf_wr_en_i,
    input  logic [XLEN-1:0]   iadder_i,
    input  logic              branch_taken_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] payload_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rf_wr_en_o,
    output logic [XLEN-1:0]   iadder_o
);

    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] tgt,
                                                     input logic taken);
        logic [XLEN-1:0] res;
        if ((ALIGN_TARGET != 0) && taken) begin
            res = {tgt[XLEN-1:1], 1'b0};
        end else begin
            res = tgt;
        end
        return res;
    endfunction

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] payload_q,  payload_d;
    logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic [XLEN-1:0]   iadder_q,   iadder_d;

    // Next-state: clear, load (with target alignment) or hold.
    always_comb begin
        valid_d    = valid_q;
        payload_d  = payload_q;
        rd_addr_d  = rd_addr_q;
        rf_wr_en_d = rf_wr_en_q;
        iadder_d   = iadder_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d    = 1'b1;
            payload_d  = payload_i;
            rd_addr_d  = rd_addr_i;
            rf_wr_en_d = rf_wr_en_i;
            iadder_d   = align_target(iadder_i, branch_taken_i);
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            payload_q  <= {DATA_W{1'b0}};
            rd_addr_q  <= {ADDR_W{1'b0}};
            rf_wr_en_q <= 1'b0;
            iadder_q   <= {XLEN{1'b0}};
        end else begin
            valid_q    <= valid_d;
            payload_q  <= payload_d;
            rd_addr_q  <= rd_addr_d;
            rf_wr_en_q <= rf_wr_en_d;
            iadder_q   <= iadder_d;
        end
    end

    assign valid_o    = valid_q;
    assign payload_o  = payload_q;
    assign rd_addr_o  = rd_addr_q;
    assign rf_wr_en_o = rf_wr_en_q;
    assign iadder_o   = iadder_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Decode-to-execute pipeline stage register with valid/ready handshake and
// a 2-entry skid buffer (main entry drives the outputs, skid entry absorbs
// one extra instruction under back-pressure).
// Ports:
//   clk_in   stage clock, rising edge
//   rst_in   asynchronous active-low reset
//   bus      handshake/data bundle (slave view): upstream valid/ready and
//            fields, downstream valid/ready and registered fields, flush,
//            occupancy (0/1/2)
// up_ready_out depends on registered state only (no path from down_ready_in).
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DEC_EX_DATA_W,
    parameter int ZERO_INVALID = 1,
    parameter int ALIGN_TARGET = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    pipe_stage_skid_reg_if.slave bus
);

    logic              main_v_s, skid_v_s;
    logic [DATA_W-1:0] main_pl_s, skid_pl_s, main_src_pl_s;
    logic [ADDR_W-1:0] main_rd_s, skid_rd_s, main_src_rd_s;
    logic              main_we_s, skid_we_s, main_src_we_s;
    logic [XLEN-1:0]   main_ia_s, skid_ia_s, main_src_ia_s;
    logic              main_src_br_s;

    logic       up_ready_s, up_fire_s, dn_fire_s;
    logic       main_load_s, main_clear_s, main_from_skid_s;
    logic       skid_load_s, skid_clear_s;
    occ_state_e state_s;

    assign up_ready_s = ~skid_v_s;
    assign up_fire_s  = bus.up_valid_in & up_ready_s;
    assign dn_fire_s  = main_v_s & bus.down_ready_in;
    assign state_s    = occ_state_e'(occ_encode(main_v_s, skid_v_s));

    // Occupancy control: decide which entries load or clear this cycle.
    always_comb begin
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (bus.flush_in) begin
            // Flush beats a simultaneous up_fire: the offered entry is dropped.
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_s)
                ST_EMPTY: begin
                    main_load_s = up_fire_s;
                end
                ST_ONE: begin
                    if (up_fire_s && dn_fire_s) begin
                        main_load_s = 1'b1;
                    end else if (up_fire_s) begin
                        skid_load_s = 1'b1;
                    end else if (dn_fire_s) begin
                        main_clear_s = 1'b1;
                    end else begin
                        main_load_s = 1'b0;
                    end
                end
                ST_FULL: begin
                    // Skid is already aligned, so it is reloaded with branch_taken forced low.
                    if (dn_fire_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                    end else begin
                        main_load_s = 1'b0;
                    end
                end
                default: begin
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    // Main-entry source select: skid entry when draining FULL, else upstream.
    always_comb begin
        main_src_pl_s = bus.payload_in;
        main_src_rd_s = bus.rd_addr_in;
        main_src_we_s = bus.rf_wr_en_in;
        main_src_ia_s = bus.iadder_in;
        main_src_br_s = bus.branch_taken_in;
        if (main_from_skid_s) begin
            main_src_pl_s = skid_pl_s;
            main_src_rd_s = skid_rd_s;
            main_src_we_s = skid_we_s;
            main_src_ia_s = skid_ia_s;
            main_src_br_s = 1'b0;
        end else begin
            main_src_br_s = bus.branch_taken_in;
        end
    end

    stage_entry_reg #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ALIGN_TARGET(ALIGN_TARGET)
    ) u_main (
        .clk_i(clk_in), .rst_ni(rst_in),
        .clear_i(main_clear_s), .load_i(main_load_s),
        .payload_i(main_src_pl_s), .rd_addr_i(main_src_rd_s),
        .rf_wr_en_i(main_src_we_s), .iadder_i(main_src_ia_s),
        .branch_taken_i(main_src_br_s),
        .valid_o(main_v_s), .payload_o(main_pl_s), .rd_addr_o(main_rd_s),
        .rf_wr_en_o(main_we_s), .iadder_o(main_ia_s)
    );

    stage_entry_reg #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ALIGN_TARGET(ALIGN_TARGET)
    ) u_skid (
        .clk_i(clk_in), .rst_ni(rst_in),
        .clear_i(skid_clear_s), .load_i(skid_load_s),
        .payload_i(bus.payload_in), .rd_addr_i(bus.rd_addr_in),
        .rf_wr_en_i(bus.rf_wr_en_in), .iadder_i(bus.iadder_in),
        .branch_taken_i(bus.branch_taken_in),
        .valid_o(skid_v_s), .payload_o(skid_pl_s), .rd_addr_o(skid_rd_s),
        .rf_wr_en_o(skid_we_s), .iadder_o(skid_ia_s)
    );

    localparam bit ZERO_EN = (ZERO_INVALID != 0);
    logic gate_s;
    assign gate_s = ZERO_EN & ~main_v_s;

    assign bus.up_ready_out   = up_ready_s;
    assign bus.down_valid_out = main_v_s;
    assign bus.rf_wr_en_out   = main_v_s & main_we_s;
    assign bus.payload_out    = gate_s ? {DATA_W{1'b0}} : main_pl_s;
    assign bus.rd_addr_out    = gate_s ? {ADDR_W{1'b0}} : main_rd_s;
    assign bus.iadder_out     = gate_s ? {XLEN{1'b0}}   : main_ia_s;
    assign bus.occupancy_out  = occ_encode(main_v_s, skid_v_s);

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;
    import pipe_stage_skid_reg_pkg::*;

    localparam int XW = 32;
    localparam int AW = 5;
    localparam int DW = 112;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_stage_skid_reg_if #(.XLEN(XW), .ADDR_W(AW), .DATA_W(DW)) if0 ();
    pipe_stage_skid_reg_if #(.XLEN(XW), .ADDR_W(AW), .DATA_W(DW)) if1 ();

    // Second instance (no alignment) sees the same input stream.
    assign if1.flush_in        = if0.flush_in;
    assign if1.up_valid_in     = if0.up_valid_in;
    assign if1.payload_in      = if0.payload_in;
    assign if1.rd_addr_in      = if0.rd_addr_in;
    assign if1.rf_wr_en_in     = if0.rf_wr_en_in;
    assign if1.iadder_in       = if0.iadder_in;
    assign if1.branch_taken_in = if0.branch_taken_in;
    assign if1.down_ready_in   = if0.down_ready_in;

    pipe_stage_skid_reg #(.XLEN(XW), .ADDR_W(AW), .DATA_W(DW),
                          .ZERO_INVALID(1), .ALIGN_TARGET(1))
        u_dut (.clk_in(clk), .rst_in(rst_n), .bus(if0));

    pipe_stage_skid_reg #(.XLEN(XW), .ADDR_W(AW), .DATA_W(DW),
                          .ZERO_INVALID(1), .ALIGN_TARGET(0))
        u_dut_na (.clk_in(clk), .rst_in(rst_n), .bus(if1));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic uv, input logic [AW-1:0] rd, input logic dr, input logic fl);
        if0.up_valid_in     = uv;
        if0.rd_addr_in      = rd;
        if0.payload_in      = DW'({rd, 8'h5A});
        if0.rf_wr_en_in     = 1'b1;
        if0.iadder_in       = 32'h0000_2000;
        if0.branch_taken_in = 1'b0;
        if0.down_ready_in   = dr;
        if0.flush_in        = fl;
    endtask

    task automatic check_empty(input string tag);
        check_val({tag, "_dv"},   128'(if0.down_valid_out), 128'd0);
        check_val({tag, "_we"},   128'(if0.rf_wr_en_out),   128'd0);
        check_val({tag, "_occ"},  128'(if0.occupancy_out),  128'd0);
        check_val({tag, "_rdy"},  128'(if0.up_ready_out),   128'd1);
        check_val({tag, "_ia"},   128'(if0.iadder_out),     128'd0);
        check_val({tag, "_rd"},   128'(if0.rd_addr_out),    128'd0);
    endtask

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] pl;
        logic          we;
        logic [XW-1:0] ia;
    } ent_t;

    ent_t sb[$];

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_empty("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_empty("post_reset");

        // Streaming: 8 back-to-back entries, each visible one edge later.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, AW'(i), 1'b1, 1'b0);
            tick();
            check_val("stream_rd",  128'(if0.rd_addr_out),    128'(i));
            check_val("stream_dv",  128'(if0.down_valid_out), 128'd1);
            check_val("stream_occ", 128'(if0.occupancy_out),  128'd1);
        end
        check_val("stream_we", 128'(if0.rf_wr_en_out), 128'd1);
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_empty("stream_drain");

        // Back-pressure: A(3) held, B(4) to skid, C(5) stalls.
        drive(1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        check_val("bp_a_rd",  128'(if0.rd_addr_out),   128'd3);
        check_val("bp_a_occ", 128'(if0.occupancy_out), 128'd1);
        drive(1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        check_val("bp_b_occ", 128'(if0.occupancy_out), 128'd2);
        check_val("bp_b_rdy", 128'(if0.up_ready_out),  128'd0);
        check_val("bp_b_rd",  128'(if0.rd_addr_out),   128'd3);
        drive(1'b1, 5'd5, 1'b0, 1'b0);
        tick();
        check_val("bp_c_occ", 128'(if0.occupancy_out), 128'd2);
        check_val("bp_c_rd",  128'(if0.rd_addr_out),   128'd3);
        drive(1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        check_val("bp_rel1_rd",  128'(if0.rd_addr_out),   128'd4);
        check_val("bp_rel1_occ", 128'(if0.occupancy_out), 128'd1);
        check_val("bp_rel1_rdy", 128'(if0.up_ready_out),  128'd1);
        tick();
        check_val("bp_rel2_rd",  128'(if0.rd_addr_out),   128'd5);
        check_val("bp_rel2_occ", 128'(if0.occupancy_out), 128'd1);
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_empty("bp_drain");

        // Flush while full with an offered entry rd=9.
        drive(1'b1, 5'd6, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b0, 1'b0);
        tick();
        check_val("fl_full_occ", 128'(if0.occupancy_out), 128'd2);
        drive(1'b1, 5'd9, 1'b0, 1'b1);
        tick();
        check_empty("flush");
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_empty("flush_after");
        drive(1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        check_empty("flush_empty");

        // Alignment, with and without ALIGN_TARGET.
        drive(1'b1, 5'd10, 1'b1, 1'b0);
        if0.iadder_in       = 32'h0000_1003;
        if0.branch_taken_in = 1'b1;
        tick();
        check_val("align_tk",    128'(if0.iadder_out), 128'h1002);
        check_val("noalign_tk",  128'(if1.iadder_out), 128'h1003);
        if0.branch_taken_in = 1'b0;
        tick();
        check_val("align_nt",    128'(if0.iadder_out), 128'h1003);
        check_val("noalign_nt",  128'(if1.iadder_out), 128'h1003);
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        tick();

        // Aligned target must survive the skid path too.
        drive(1'b1, 5'd13, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd14, 1'b0, 1'b0);
        if0.iadder_in       = 32'h0000_4441;
        if0.branch_taken_in = 1'b1;
        tick();
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check_val("skid_align_rd", 128'(if0.rd_addr_out), 128'd14);
        check_val("skid_align_ia", 128'(if0.iadder_out),  128'h4440);
        tick();

        // Asynchronous reset mid-stream with occupancy 2.
        drive(1'b1, 5'd11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd12, 1'b0, 1'b0);
        tick();
        check_val("rst_mid_occ", 128'(if0.occupancy_out), 128'd2);
        rst_n = 1'b0;
        #1;
        check_empty("rst_mid");
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_empty("rst_resume");

        // Random valid/ready/flush against a depth-2 FIFO reference.
        sb.delete();
        for (int c = 0; c < 10000; c++) begin
            logic uv, dr, fl, br, we;
            logic [127:0] pl;
            logic [XW-1:0] ia;
            ent_t e;
            int sz;
            uv = 1'($urandom_range(0, 1));
            dr = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 99) < 5);
            br = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            pl = {$urandom, $urandom, $urandom, $urandom};
            ia = $urandom;
            if0.up_valid_in     = uv;
            if0.rd_addr_in      = AW'(c);
            if0.payload_in      = pl[DW-1:0];
            if0.rf_wr_en_in     = we;
            if0.iadder_in       = ia;
            if0.branch_taken_in = br;
            if0.down_ready_in   = dr;
            if0.flush_in        = fl;
            e.rd = AW'(c);
            e.pl = pl[DW-1:0];
            e.we = we;
            e.ia = br ? {ia[XW-1:1], 1'b0} : ia;
            sz = sb.size();
            if (fl) begin
                sb.delete();
            end else begin
                if (sz > 0 && dr) void'(sb.pop_front());
                if (uv && sz < 2) sb.push_back(e);
            end
            tick();
            check_val("rnd_occ", 128'(if0.occupancy_out),  128'(sb.size()));
            check_val("rnd_dv",  128'(if0.down_valid_out), 128'(sb.size() > 0));
            check_val("rnd_rdy", 128'(if0.up_ready_out),   128'(sb.size() < 2));
            check_val("rnd_we_gate", 128'(if0.rf_wr_en_out & ~if0.down_valid_out), 128'd0);
            if (sb.size() > 0) begin
                check_val("rnd_rd", 128'(if0.rd_addr_out),  128'(sb[0].rd));
                check_val("rnd_pl", 128'(if0.payload_out),  128'(sb[0].pl));
                check_val("rnd_we", 128'(if0.rf_wr_en_out), 128'(sb[0].we));
                check_val("rnd_ia", 128'(if0.iadder_out),   128'(sb[0].ia));
            end else begin
                check_val("rnd_zero_rd", 128'(if0.rd_addr_out), 128'd0);
                check_val("rnd_zero_pl", 128'(if0.payload_out), 128'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
